// File: rtl/tt_sel_seq.sv
// Design-select pin sequencer: resets the chip's selector, pulses inc addr times, then applies ena.
// A request for the already-selected address only updates ena.
module tt_sel_seq #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned PULSE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              cur_valid,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);

  localparam int unsigned CNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DIS, S_RST, S_REL, S_INC_HI, S_INC_LO, S_ENA
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [ADDR_W-1:0] pcnt, pcnt_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic              ena_q, ena_nx;
  logic              phase_end;

  logic              ready_nx, busy_nx, done_nx, cur_valid_nx;
  logic [ADDR_W-1:0] cur_addr_nx;
  logic              sel_rst_n_nx, sel_inc_nx, ctrl_ena_nx;

  assign phase_end = (cnt == '0);

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt - 1'b1;
    pcnt_nx      = pcnt;
    addr_nx      = addr_q;
    ena_nx       = ena_q;
    done_nx      = 1'b0;
    cur_valid_nx = cur_valid;
    cur_addr_nx  = cur_addr;
    sel_rst_n_nx = ctrl_sel_rst_n;
    ctrl_ena_nx  = ctrl_ena;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          addr_nx  = req_addr;
          ena_nx   = req_ena;
          pcnt_nx  = req_addr;
          cnt_nx   = CNT_LOAD;
          state_nx = (cur_valid && (req_addr == cur_addr)) ? S_ENA : S_DIS;
        end
      end
      S_DIS: if (phase_end) begin state_nx = S_RST; cnt_nx = CNT_LOAD; end
      S_RST: if (phase_end) begin state_nx = S_REL; cnt_nx = CNT_LOAD; end
      S_REL: begin
        if (phase_end) begin
          state_nx = (pcnt == '0) ? S_ENA : S_INC_HI;
          cnt_nx   = CNT_LOAD;
        end
      end
      S_INC_HI: begin
        if (phase_end) begin
          state_nx = S_INC_LO;
          cnt_nx   = CNT_LOAD;
          pcnt_nx  = pcnt - 1'b1;
        end
      end
      S_INC_LO: begin
        if (phase_end) begin
          state_nx = (pcnt == '0) ? S_ENA : S_INC_HI;
          cnt_nx   = CNT_LOAD;
        end
      end
      S_ENA:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    if (abort && (state != S_IDLE) && (state != S_ENA))
      state_nx = S_IDLE;

    // Pin levels are decoded from the upcoming state so every output is a plain register.
    case (state_nx)
      S_DIS: begin
        ctrl_ena_nx  = 1'b0;
        cur_valid_nx = 1'b0;
      end
      S_RST: sel_rst_n_nx = 1'b0;
      S_REL: sel_rst_n_nx = 1'b1;
      S_ENA: begin
        ctrl_ena_nx  = ena_nx;
        cur_addr_nx  = addr_nx;
        cur_valid_nx = 1'b1;
        done_nx      = 1'b1;
      end
      S_IDLE: begin
        if ((state != S_IDLE) && (state != S_ENA)) begin
          ctrl_ena_nx  = 1'b0;
          sel_rst_n_nx = 1'b0;
          cur_valid_nx = 1'b0;
        end
      end
      default: ;
    endcase

    sel_inc_nx = (state_nx == S_INC_HI);
    busy_nx    = (state_nx != S_IDLE);
    ready_nx   = (state_nx == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      pcnt           <= '0;
      addr_q         <= '0;
      ena_q          <= 1'b0;
      req_ready      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      cur_valid      <= 1'b0;
      cur_addr       <= '0;
      ctrl_sel_rst_n <= 1'b0;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      pcnt           <= pcnt_nx;
      addr_q         <= addr_nx;
      ena_q          <= ena_nx;
      req_ready      <= ready_nx;
      busy           <= busy_nx;
      done           <= done_nx;
      cur_valid      <= cur_valid_nx;
      cur_addr       <= cur_addr_nx;
      ctrl_sel_rst_n <= sel_rst_n_nx;
      ctrl_sel_inc   <= sel_inc_nx;
      ctrl_ena       <= ctrl_ena_nx;
    end
  end

endmodule

// File: tb/tb_tt_sel_seq.sv
// Directed bench for tt_sel_seq: expected completions are queued at request time and
// checked against what a pin monitor observes when done fires.
module tb_tt_sel_seq;
  localparam int unsigned AW = 10;
  localparam int unsigned P  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          req_ena = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, cur_valid;
  logic [AW-1:0] cur_addr;
  logic          ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;

  tt_sel_seq #(.ADDR_W(AW), .PULSE_CYC(P)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_ena(req_ena), .abort(abort), .busy(busy),
    .done(done), .cur_valid(cur_valid), .cur_addr(cur_addr),
    .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          ena;
    int            lat;
    int            pulses;
    int            low;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails  = 0;

  // Bench's view of the chip selector after all queued requests complete.
  bit            m_valid = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  bit            m_rstn  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pin monitor, sampling on the falling edge.
  int cyc = 0, acc_cyc = 0, last_done_cyc = -10, ready_due = -1;
  int pulses = 0, rst_low = 0, run_len = 0;
  bit inc_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      inc_prev  = 1'b0;
      run_len   = 0;
      ready_due = -1;
    end else begin
      if (done) begin
        check("done_expected", {31'd0, q.size() != 0}, 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("latency", cyc - acc_cyc, e.lat);
          check("inc_pulses", pulses, e.pulses);
          check("rst_low_cycles", rst_low, e.low);
          check("ctrl_ena_at_done", {31'd0, ctrl_ena}, {31'd0, e.ena});
          check("cur_addr_at_done", {22'd0, cur_addr}, {22'd0, e.addr});
          check("cur_valid_at_done", {31'd0, cur_valid}, 32'd1);
          check("ready_low_at_done", {31'd0, req_ready}, 32'd0);
        end
        last_done_cyc = cyc;
        ready_due     = cyc + 1;
      end
      if (cyc == ready_due) check("ready_after_done", {31'd0, req_ready}, 32'd1);
      if (ctrl_sel_inc && !inc_prev) pulses++;
      if (ctrl_sel_inc) run_len++;
      if (!ctrl_sel_inc && inc_prev) begin
        check("inc_high_len", run_len, P);
        run_len = 0;
      end
      inc_prev = ctrl_sel_inc;
      if (busy && !ctrl_sel_rst_n) rst_low++;
      if (req_valid && req_ready) begin
        acc_cyc = cyc;
        pulses  = 0;
        rst_low = 0;
      end
    end
  end

  task automatic send(input logic [AW-1:0] a, input logic e, input bit push, input bit keep);
    exp_t x;
    bit   fast, got;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_ena = e;
    if (push) begin
      fast     = m_valid && (a == m_addr);
      x.addr   = a;
      x.ena    = e;
      x.lat    = fast ? 1 : (3 + 2 * int'(a)) * P + 1;
      x.pulses = fast ? 0 : int'(a);
      x.low    = fast ? 0 : (m_rstn ? P : 2 * P);
      q.push_back(x);
      m_valid = 1'b1; m_addr = a; m_rstn = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
    end
    check("accept_in_time", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    if (!keep) begin
      req_valid = 1'b0; req_addr = ~a; req_ena = ~e;
    end
  endtask

  task automatic wait_idle(input string tag);
    bit idle = 1'b0;
    for (int i = 0; i < 500 && !idle; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) idle = 1'b1;
    end
    check(tag, {31'd0, idle}, 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rst_n"}, {31'd0, ctrl_sel_rst_n}, 32'd0);
    check({tag, "_inc"}, {31'd0, ctrl_sel_inc}, 32'd0);
    check({tag, "_ena"}, {31'd0, ctrl_ena}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_cur_valid"}, {31'd0, cur_valid}, 32'd0);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    bit hit;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("reset");
    check("reset_cur_addr", {22'd0, cur_addr}, 32'd0);

    // 1: address 0, no inc pulses
    send(10'd0, 1'b1, 1'b1, 1'b0);
    wait_idle("t1_idle");

    // 2: address 3 full path; 3: same address, ena-only fast path
    send(10'd3, 1'b1, 1'b1, 1'b0);
    wait_idle("t2_idle");
    send(10'd3, 1'b0, 1'b1, 1'b0);
    wait_idle("t3_idle");

    // 4: abort during the second INC_HI
    send(10'd5, 1'b1, 1'b0, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (pulses == 2 && ctrl_sel_inc) hit = 1'b1;
    end
    check("t4_reach_inc2", {31'd0, hit}, 32'd1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check_quiet("abort");
    m_valid = 1'b0; m_rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", {31'd0, done}, 32'd0);
    send(10'd5, 1'b1, 1'b1, 1'b0);
    wait_idle("t4_idle");

    // 5: reset in the RST phase
    send(10'd2, 1'b1, 1'b0, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (busy && !ctrl_sel_rst_n) hit = 1'b1;
    end
    check("t5_reach_rst", {31'd0, hit}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("midrst");
    check("midrst_cur_addr", {22'd0, cur_addr}, 32'd0);
    m_valid = 1'b0; m_rstn = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_not_resumed", {31'd0, busy}, 32'd0);

    // 6: back-to-back with req_valid held high
    send(10'd1, 1'b1, 1'b1, 1'b1);
    send(10'd2, 1'b1, 1'b1, 1'b0);
    check("b2b_accept_cycle", acc_cyc, last_done_cyc + 1);
    wait_idle("t6_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
